// File: rtl/stage_memory_pkg.sv
// Shared RISC-V load/store definitions for the memory stage: funct3 encodings,
// FSM state type, byte-enable patterns and access legality helpers.
package stage_memory_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } mem_state_t;

    function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
        if (is_store)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Drops the low address bits a half or word access cannot legally use.
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b01:   return {offset[1], 1'b0};
            2'b10:   return 2'b00;
            default: return offset;
        endcase
    endfunction

endpackage

// File: rtl/stage_memory_load_store_align.sv
// Combinational lane steering for the memory stage: byte enables, store data
// replication and load lane selection with sign/zero extension.
module load_store_align
    import stage_memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_value
);

    logic [7:0]  read_byte;
    logic [15:0] read_half;
    logic        zero_ext;

    assign read_byte = read_data[{offset, 3'b000} +: 8];
    assign read_half = read_data[{offset[1], 4'b0000} +: 16];
    assign zero_ext  = funct3[2];

    always_comb begin
        byte_en    = BE_WORD;
        write_data = store_data;
        load_value = read_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = BE_BYTE << offset;
                write_data = {4{store_data[7:0]}};
                load_value = zero_ext ? {24'h0, read_byte} : {{24{read_byte[7]}}, read_byte};
            end
            2'b01: begin
                byte_en    = BE_HALF << {offset[1], 1'b0};
                write_data = {2{store_data[15:0]}};
                load_value = zero_ext ? {16'h0, read_half} : {{16{read_half[15]}}, read_half};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Pipeline memory stage: issues one bus transaction per load/store, stalls
// upstream until ack or timeout. Define MISALIGNED_TRAP_EN to fault misaligned accesses.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int BUS_TIMEOUT_CYCLES = 256
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_StoreData,
    input  logic [2:0]  i_Funct3,
    input  logic [4:0]  i_rd,
    input  logic        i_RegWrite,
    output logic        o_BusReq,
    output logic        o_BusWrite,
    output logic [31:0] o_BusAddr,
    output logic [31:0] o_BusWData,
    output logic [3:0]  o_BusByteEn,
    input  logic        i_BusAck,
    input  logic [31:0] i_BusRData,
    output logic [31:0] o_WritebackValue,
    output logic [4:0]  o_rd,
    output logic        o_RegWrite,
    output logic        o_Stall,
    output logic        o_Exception
);

    localparam int CW = $clog2(BUS_TIMEOUT_CYCLES) + 1;

    mem_state_t    state;
    mem_state_t    next_state;
    logic [CW-1:0] count;

    logic        is_request;
    logic        access_bad;
    logic        misaligned_fault;
    logic        fault;
    logic        start;
    logic        ack_hit;
    logic        timeout_hit;
    logic [1:0]  req_offset;

    logic [2:0]  lat_funct3;
    logic [1:0]  lat_offset;
    logic [4:0]  lat_rd;
    logic        lat_regwrite;
    logic        lat_store;

    logic [2:0]  align_funct3;
    logic [1:0]  align_off;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    assign is_request = i_MemRead | i_MemWrite;

`ifdef MISALIGNED_TRAP_EN
    assign misaligned_fault = is_misaligned(i_Funct3[1:0], i_Address[1:0]);
`else
    assign misaligned_fault = 1'b0;
`endif

    assign access_bad  = (i_MemRead & i_MemWrite) || !funct3_legal(i_Funct3, i_MemWrite) ||
                         misaligned_fault;
    assign fault       = (state == ST_IDLE) && is_request && access_bad;
    assign start       = (state == ST_IDLE) && is_request && !access_bad;
    assign ack_hit     = (state == ST_ACCESS) && i_BusAck;
    assign timeout_hit = (state == ST_ACCESS) && !i_BusAck &&
                         (count == CW'(BUS_TIMEOUT_CYCLES - 1));
    assign req_offset  = align_offset(i_Funct3[1:0], i_Address[1:0]);

    // The aligner serves the request inputs in IDLE and the latched load during ACCESS.
    assign align_funct3 = (state == ST_ACCESS) ? lat_funct3 : i_Funct3;
    assign align_off    = (state == ST_ACCESS) ? lat_offset : req_offset;

    load_store_align u_align (
        .funct3     (align_funct3),
        .offset     (align_off),
        .store_data (i_StoreData),
        .read_data  (i_BusRData),
        .byte_en    (align_be),
        .write_data (align_wdata),
        .load_value (align_load)
    );

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_ACCESS;
            ST_ACCESS: if (ack_hit || timeout_hit) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_Stall = 1'b0;
        case (state)
            ST_IDLE:   o_Stall = start;
            ST_ACCESS: o_Stall = !(i_BusAck || timeout_hit);
            default:   o_Stall = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            count <= '0;
        else if (state == ST_ACCESS && next_state == ST_ACCESS)
            count <= count + CW'(1);
        else
            count <= '0;
    end

    // Bus outputs are loaded once at request time so they stay stable through ACCESS.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_BusReq     <= 1'b0;
            o_BusWrite   <= 1'b0;
            o_BusAddr    <= '0;
            o_BusWData   <= '0;
            o_BusByteEn  <= '0;
            lat_funct3   <= '0;
            lat_offset   <= '0;
            lat_rd       <= '0;
            lat_regwrite <= 1'b0;
            lat_store    <= 1'b0;
        end else if (start) begin
            o_BusReq     <= 1'b1;
            o_BusWrite   <= i_MemWrite;
            o_BusAddr    <= {i_Address[31:2], 2'b00};
            o_BusWData   <= align_wdata;
            o_BusByteEn  <= align_be;
            lat_funct3   <= i_Funct3;
            lat_offset   <= req_offset;
            lat_rd       <= i_rd;
            lat_regwrite <= i_RegWrite;
            lat_store    <= i_MemWrite;
        end else if (ack_hit || timeout_hit) begin
            o_BusReq <= 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_WritebackValue <= '0;
            o_rd             <= '0;
            o_RegWrite       <= 1'b0;
            o_Exception      <= 1'b0;
        end else begin
            o_Exception <= fault | timeout_hit;
            if (state == ST_IDLE) begin
                if (fault || start) begin
                    o_RegWrite <= 1'b0;
                end else begin
                    o_WritebackValue <= i_Address;
                    o_rd             <= i_rd;
                    o_RegWrite       <= i_RegWrite;
                end
            end else if (ack_hit) begin
                o_rd       <= lat_rd;
                o_RegWrite <= lat_regwrite & ~lat_store;
                if (!lat_store) o_WritebackValue <= align_load;
            end else begin
                o_RegWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: table of load/store/nop vectors with a result
// scoreboard, plus hand sequences for timeout and mid-access reset.
module tb_stage_memory;

    localparam int TIMEOUT = 8;
    localparam int NUM_VEC = 16;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [31:0] i_Address;
    logic [31:0] i_StoreData;
    logic [2:0]  i_Funct3;
    logic [4:0]  i_rd;
    logic        i_RegWrite;
    logic        o_BusReq;
    logic        o_BusWrite;
    logic [31:0] o_BusAddr;
    logic [31:0] o_BusWData;
    logic [3:0]  o_BusByteEn;
    logic        i_BusAck;
    logic [31:0] i_BusRData;
    logic [31:0] o_WritebackValue;
    logic [4:0]  o_rd;
    logic        o_RegWrite;
    logic        o_Stall;
    logic        o_Exception;

    stage_memory #(.BUS_TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_Clock          (i_Clock),
        .i_Reset_n        (i_Reset_n),
        .i_MemRead        (i_MemRead),
        .i_MemWrite       (i_MemWrite),
        .i_Address        (i_Address),
        .i_StoreData      (i_StoreData),
        .i_Funct3         (i_Funct3),
        .i_rd             (i_rd),
        .i_RegWrite       (i_RegWrite),
        .o_BusReq         (o_BusReq),
        .o_BusWrite       (o_BusWrite),
        .o_BusAddr        (o_BusAddr),
        .o_BusWData       (o_BusWData),
        .o_BusByteEn      (o_BusByteEn),
        .i_BusAck         (i_BusAck),
        .i_BusRData       (i_BusRData),
        .o_WritebackValue (o_WritebackValue),
        .o_rd             (o_rd),
        .o_RegWrite       (o_RegWrite),
        .o_Stall          (o_Stall),
        .o_Exception      (o_Exception)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        regwrite;
        logic [31:0] rdata;
        int          ack_delay;
        logic        exp_req;
        logic [31:0] exp_bus_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        check_wb;
        logic [31:0] exp_wb;
        logic        exp_regwrite;
        logic        exp_exc;
    } vec_t;

    typedef struct {
        logic        check_wb;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        regwrite;
        logic        exc;
    } exp_t;

    vec_t vecs [NUM_VEC];
    exp_t sb_queue [$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t makeVec(
        input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] addr,
        input logic [31:0] sdata, input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
        input int delay, input logic req, input logic [31:0] baddr, input logic [3:0] be,
        input logic [31:0] wdata, input logic cwb, input logic [31:0] wb, input logic erw,
        input logic exc);
        vec_t v;
        v.mem_read = mr;      v.mem_write = mw;     v.funct3 = f3;
        v.addr = addr;        v.store_data = sdata; v.rd = rd;
        v.regwrite = rw;      v.rdata = rdata;      v.ack_delay = delay;
        v.exp_req = req;      v.exp_bus_addr = baddr; v.exp_be = be;
        v.exp_wdata = wdata;  v.check_wb = cwb;     v.exp_wb = wb;
        v.exp_regwrite = erw; v.exp_exc = exc;
        return v;
    endfunction

    task automatic stepCycle();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveNop(input logic [31:0] addr, input logic [4:0] rd, input logic rw);
        i_MemRead  = 1'b0;
        i_MemWrite = 1'b0;
        i_Address  = addr;
        i_StoreData = 32'h0;
        i_Funct3   = 3'b000;
        i_rd       = rd;
        i_RegWrite = rw;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        i_MemRead   = v.mem_read;
        i_MemWrite  = v.mem_write;
        i_Address   = v.addr;
        i_StoreData = v.store_data;
        i_Funct3    = v.funct3;
        i_rd        = v.rd;
        i_RegWrite  = v.regwrite;
        e.check_wb = v.check_wb;
        e.wb       = v.exp_wb;
        e.rd       = v.rd;
        e.regwrite = v.exp_regwrite;
        e.exc      = v.exp_exc;
        sb_queue.push_back(e);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb_queue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_sb: got empty scoreboard, want one entry", name);
            return;
        end
        e = sb_queue.pop_front();
        checkVal({name, "_regwrite"}, {31'h0, o_RegWrite}, {31'h0, e.regwrite});
        checkVal({name, "_exc"}, {31'h0, o_Exception}, {31'h0, e.exc});
        if (e.check_wb) begin
            checkVal({name, "_wb"}, o_WritebackValue, e.wb);
            checkVal({name, "_rd"}, {27'h0, o_rd}, {27'h0, e.rd});
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        string n;
        int    stall_cycles;
        n = $sformatf("v%0d", idx);
        applyStimulus(v);
        #1;
        checkVal({n, "_stall_req"}, {31'h0, o_Stall}, {31'h0, v.exp_req});
        if (v.exp_req) begin
            stall_cycles = 1;
            stepCycle();
            checkVal({n, "_busreq"}, {31'h0, o_BusReq}, 32'h1);
            checkVal({n, "_buswrite"}, {31'h0, o_BusWrite}, {31'h0, v.mem_write});
            checkVal({n, "_busaddr"}, o_BusAddr, v.exp_bus_addr);
            checkVal({n, "_byteen"}, {28'h0, o_BusByteEn}, {28'h0, v.exp_be});
            if (v.mem_write) checkVal({n, "_wdata"}, o_BusWData, v.exp_wdata);
            for (int k = 0; k < v.ack_delay; k++) begin
                if (o_Stall) stall_cycles++;
                stepCycle();
            end
            checkVal({n, "_hold_addr"}, o_BusAddr, v.exp_bus_addr);
            i_BusAck   = 1'b1;
            i_BusRData = v.rdata;
            #1;
            checkVal({n, "_stall_ack"}, {31'h0, o_Stall}, 32'h0);
            checkVal({n, "_stall_len"}, stall_cycles, v.ack_delay + 1);
            stepCycle();
            i_BusAck = 1'b0;
            checkOutput(n);
            checkVal({n, "_busreq_drop"}, {31'h0, o_BusReq}, 32'h0);
        end else begin
            stepCycle();
            checkOutput(n);
            checkVal({n, "_noreq"}, {31'h0, o_BusReq}, 32'h0);
            if (v.exp_exc) begin
                driveNop(32'h0, 5'd0, 1'b0);
                stepCycle();
                checkVal({n, "_exc_pulse"}, {31'h0, o_Exception}, 32'h0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busreq_cycles;
        vecs[0]  = makeVec(0, 0, 3'b000, 32'h12345678, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0);
        vecs[1]  = makeVec(1, 0, 3'b010, 32'h00000100, 0, 5'd5, 1, 32'hCAFEBABE, 3, 1, 32'h100, 4'b1111, 0, 1, 32'hCAFEBABE, 1, 0);
        vecs[2]  = makeVec(1, 0, 3'b000, 32'h00000103, 0, 5'd6, 1, 32'h80112233, 1, 1, 32'h100, 4'b1000, 0, 1, 32'hFFFFFF80, 1, 0);
        vecs[3]  = makeVec(1, 0, 3'b100, 32'h00000103, 0, 5'd6, 1, 32'h80112233, 0, 1, 32'h100, 4'b1000, 0, 1, 32'h00000080, 1, 0);
        vecs[4]  = makeVec(0, 1, 3'b001, 32'h00000202, 32'h0000BEEF, 5'd4, 1, 0, 1, 1, 32'h200, 4'b1100, 32'hBEEFBEEF, 0, 0, 0, 0);
        vecs[5]  = makeVec(1, 0, 3'b001, 32'h00000102, 0, 5'd8, 1, 32'h80112233, 2, 1, 32'h100, 4'b1100, 0, 1, 32'hFFFF8011, 1, 0);
        vecs[6]  = makeVec(1, 0, 3'b101, 32'h00000100, 0, 5'd9, 1, 32'h80118233, 0, 1, 32'h100, 4'b0011, 0, 1, 32'h00008233, 1, 0);
        vecs[7]  = makeVec(0, 1, 3'b000, 32'h00000301, 32'h000000A5, 5'd2, 0, 0, 0, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 0, 0, 0, 0);
        vecs[8]  = makeVec(0, 1, 3'b010, 32'h00000400, 32'h11223344, 5'd2, 0, 0, 2, 1, 32'h400, 4'b1111, 32'h11223344, 0, 0, 0, 0);
        vecs[9]  = makeVec(1, 0, 3'b011, 32'h00000500, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[10] = makeVec(0, 1, 3'b100, 32'h00000500, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[11] = makeVec(1, 1, 3'b010, 32'h00000500, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[12] = makeVec(1, 0, 3'b110, 32'h00000500, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef MISALIGNED_TRAP_EN
        vecs[13] = makeVec(1, 0, 3'b010, 32'h00000101, 0, 5'd10, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
        vecs[13] = makeVec(1, 0, 3'b010, 32'h00000101, 0, 5'd10, 1, 32'hDEADBEEF, 1, 1, 32'h100, 4'b1111, 0, 1, 32'hDEADBEEF, 1, 0);
`endif
        vecs[14] = makeVec(1, 0, 3'b010, 32'h00000104, 0, 5'd3, 0, 32'h01020304, 2, 1, 32'h104, 4'b1111, 0, 1, 32'h01020304, 0, 0);
        vecs[15] = makeVec(0, 0, 3'b000, 32'h0000ABCD, 0, 5'd11, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000ABCD, 0, 0);

        i_Reset_n  = 1'b0;
        i_BusAck   = 1'b0;
        i_BusRData = 32'h0;
        driveNop(32'h0, 5'd0, 1'b0);
        #12;
        checkVal("rst_busreq", {31'h0, o_BusReq}, 32'h0);
        checkVal("rst_buswrite", {31'h0, o_BusWrite}, 32'h0);
        checkVal("rst_busaddr", o_BusAddr, 32'h0);
        checkVal("rst_wdata", o_BusWData, 32'h0);
        checkVal("rst_byteen", {28'h0, o_BusByteEn}, 32'h0);
        checkVal("rst_wb", o_WritebackValue, 32'h0);
        checkVal("rst_rd", {27'h0, o_rd}, 32'h0);
        checkVal("rst_regwrite", {31'h0, o_RegWrite}, 32'h0);
        checkVal("rst_exc", {31'h0, o_Exception}, 32'h0);
        stepCycle();
        i_Reset_n = 1'b1;

        // Ack while idle must not disturb anything.
        i_BusAck   = 1'b1;
        i_BusRData = 32'h99999999;
        stepCycle();
        i_BusAck = 1'b0;
        checkVal("idle_ack_busreq", {31'h0, o_BusReq}, 32'h0);
        checkVal("idle_ack_regwrite", {31'h0, o_RegWrite}, 32'h0);

        for (int i = 0; i < NUM_VEC; i++) runVector(vecs[i], i);

        // Load with no ack: request must drop after exactly TIMEOUT access cycles.
        i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Address = 32'h600;
        i_Funct3 = 3'b010; i_rd = 5'd12; i_RegWrite = 1'b1;
        stepCycle();
        busreq_cycles = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (o_BusReq) busreq_cycles++;
            if (k == TIMEOUT - 1) begin
                checkVal("to_stall_release", {31'h0, o_Stall}, 32'h0);
                driveNop(32'h0, 5'd0, 1'b0);
            end else if (k == 0) begin
                checkVal("to_stall_held", {31'h0, o_Stall}, 32'h1);
            end
            stepCycle();
        end
        checkVal("to_busreq_cycles", busreq_cycles, TIMEOUT);
        checkVal("to_busreq_drop", {31'h0, o_BusReq}, 32'h0);
        checkVal("to_exc", {31'h0, o_Exception}, 32'h1);
        checkVal("to_regwrite", {31'h0, o_RegWrite}, 32'h0);
        checkVal("to_stall_idle", {31'h0, o_Stall}, 32'h0);
        stepCycle();
        checkVal("to_exc_pulse", {31'h0, o_Exception}, 32'h0);

        // Reset mid-access, then a late ack that must be ignored.
        i_MemRead = 1'b1; i_Address = 32'h700; i_Funct3 = 3'b010;
        i_rd = 5'd13; i_RegWrite = 1'b1;
        stepCycle();
        checkVal("rst_mid_busreq_before", {31'h0, o_BusReq}, 32'h1);
        i_Reset_n = 1'b0;
        #1;
        checkVal("rst_mid_busreq", {31'h0, o_BusReq}, 32'h0);
        driveNop(32'h0, 5'd0, 1'b0);
        stepCycle();
        i_Reset_n  = 1'b1;
        i_BusAck   = 1'b1;
        i_BusRData = 32'h55AA55AA;
        stepCycle();
        i_BusAck = 1'b0;
        checkVal("late_ack_regwrite", {31'h0, o_RegWrite}, 32'h0);
        checkVal("late_ack_wb", o_WritebackValue, 32'h0);
        checkVal("late_ack_busreq", {31'h0, o_BusReq}, 32'h0);

        if (sb_queue.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_drain: got %0d entries, want 0", sb_queue.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
